ibuf_sync_filter: RTL

IBUF_SYNC_FILTER -- requirements
Module: ibuf_sync_filter

---
 rtl/ibuf_sync_filter.sv | 84 ++++++++
 1 files changed

// File: rtl/ibuf_sync_filter.sv
// Input-pad synchronizer followed by a counting deglitch filter on the synchronized level.
// Define IBUF_SYNC_FILTER_EDGE_EN to add the registered RISE/FALL edge-pulse ports.
module ibuf_sync_filter #(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_CNT = 4,
  parameter logic        INIT     = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic I,
  output logic O
`ifdef IBUF_SYNC_FILTER_EDGE_EN
  ,
  output logic RISE,
  output logic FALL
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_CNT - 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              o_q, o_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              s;

  assign s = sync_q[STAGES-1];
  assign O = o_q;

  // Any cycle where the synchronized level agrees with O discards a partial count,
  // so only an unbroken run of enabled disagreeing samples can move O.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], I};
    o_d    = o_q;
    cnt_d  = '0;
    if (s != o_q) begin
      cnt_d = cnt_q;
      if (CE) begin
        if (cnt_q == CNT_LAST) begin
          o_d   = s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      sync_q <= {STAGES{INIT}};
      o_q    <= INIT;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      o_q    <= o_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef IBUF_SYNC_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = o_d & ~o_q;
    fall_d = ~o_d & o_q;
  end

  always_ff @(posedge C) begin
    if (R) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`endif

endmodule
